cg_rvarch_decode_stage: RTL and testbench
=========================================

# cg_rvarch_decode_stage

Registered RISC-V base-integer decode stage with valid/ready handshake on both sides and a one-entry skid buffer. It sits between fetch and issue, turning a 32-bit instruction and its PC into decoded fields, an XLEN-extended immediate and class flags. It is parametrised for RV32I and RV64I, adding the `*W` opcodes when XLEN=64, and sustains one instruction per cycle under back-pressure.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  discards every held instruction.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept an instruction; registered.
- i_instr  in  32  instruction word.
- i_pc  in  XLEN  instruction address.
- o_valid  out  1  decoded instruction valid.
- i_ready  in  1  downstream accepts.
- o_pc  out  XLEN, o_instr  out  32: pass-through copies.
- o_opcode  out  7; o_rd, o_rs1, o_rs2  out  5 each; o_funct3  out  3; o_funct7  out  7.
- o_imm  out  XLEN: immediate, sign-extended to XLEN.
- o_rd_we  out  1: instruction writes rd, and rd≠0.
- o_is_branch, o_is_load, o_is_store, o_is_jump, o_is_word  out  1 each: class flags.
- o_illegal  out  1: illegal encoding.

## Operation
- Field slices: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- Immediate selection by opcode. Each immediate is sign-extended from instr[31] to XLEN.
  - I-type: JALR, LOAD, OP_IMM, OP_IMM_32.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC. Value is {instr[31:12], 12'b0}, then sign-extended.
  - J-type: JAL.
  - Any other opcode: 0.
- o_rd_we is set for LOAD, OP_IMM, AUIPC, OP, LUI, JAL, JALR, and also OP_IMM_32, OP_32 when XLEN=64. It is cleared when rd=0.
- Class flags:
  - o_is_branch = BRANCH.
  - o_is_load = LOAD.
  - o_is_store = STORE.
  - o_is_jump = JAL or JALR.
  - o_is_word = OP_IMM_32 or OP_32, and only when XLEN=64. It is constant 0 when XLEN=32.
- Storage: a main output register plus one skid register.
  - Input accepted when i_valid && o_ready && !i_flush.
  - Accept while the main register is empty, or is draining (o_valid && i_ready): decode goes into the main register.
  - Accept while the main register is stalled: decode goes into the skid register. o_ready drops on the next cycle.
  - When the main register drains and the skid register is full, the skid entry moves to the main register and o_ready rises.
  - Program order is always preserved.
- While o_valid && !i_ready, every o_* output holds stable.
- i_flush clears both valid bits on the next edge. It overrides a same-cycle accept, and that input is dropped. The same-cycle downstream handshake still completes.
- All data outputs reset to 0, o_valid to 0, and o_ready to 1.

## Timing
- Latency is 1 cycle from accept to o_valid.
- Throughput is 1 instruction per cycle when i_ready=1.
- o_ready = !skid_valid, driven from a flop. There is no combinational path from i_ready or i_valid to any output.
- Reset asserted mid-transfer clears all state immediately. After deassertion, the first accept is possible on the first edge.
- A simultaneous accept and drain with the skid register empty is a pass-through; occupancy is unchanged.

## Configuration
- CG_RVDEC_ILLEGAL_EN defined: o_illegal is registered alongside the other outputs. It is set when any of the following holds:
  - opcode[1:0] ≠ 2'b11;
  - the opcode is not one of LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM (plus OP_IMM_32, OP_32 when XLEN=64);
  - JALR with funct3 ≠ 000;
  - BRANCH with funct3 010 or 011;
  - OP with funct7 ∉ {0000000, 0100000};
  - OP with funct7=0100000 and funct3 ∉ {000, 101}.
- An illegal instruction still flows through normally, with o_rd_we forced to 0.
- CG_RVDEC_ILLEGAL_EN undefined: o_illegal is tied to 0 and no checking logic is built.

## Test plan
- XLEN=64, `addi x5,x0,-1` (0xFFF00293) → one cycle later o_valid=1, o_rd=5, o_imm=0xFFFF_FFFF_FFFF_FFFF, o_rd_we=1.
- i_ready=0 for 3 cycles while LUI 0x12345 (0x123452B7) then JAL are presented:
  - first entry held; second goes to skid; o_ready=0;
  - after i_ready=1, outputs in order: LUI with o_imm=0x12345000, then JAL with o_is_jump=1.
- i_flush with both registers full and i_valid=1 → next cycle o_valid=0, o_ready=1; the flush-cycle input never appears.
- XLEN=64, `addiw` (opcode 0011011) → o_is_word=1. XLEN=32, same word → o_is_word=0, and o_illegal=1 with the macro defined.
- Macro defined: 0x00000000 → o_illegal=1, o_rd_we=0. Macro undefined: same input → o_illegal=0.
- Assert i_rst_n=0 mid-stall → o_valid=0 and o_ready=1 immediately. Continuous streaming of 100 random legal instructions with i_ready=1 → 100 outputs in order, no bubbles.

Source files
------------

// File: rtl/cg_rvarch_decode_stage.sv
// RV32I/RV64I decode stage: registered decode with a one-entry skid buffer on a valid/ready pipe.
// Optional illegal-encoding detection is built when CG_RVDEC_ILLEGAL_EN is defined.
module cg_rvarch_decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instr,
    input  logic [XLEN-1:0]   i_pc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   o_pc,
    output logic [31:0]       o_instr,
    output logic [6:0]        o_opcode,
    output logic [4:0]        o_rd,
    output logic [4:0]        o_rs1,
    output logic [4:0]        o_rs2,
    output logic [2:0]        o_funct3,
    output logic [6:0]        o_funct7,
    output logic [XLEN-1:0]   o_imm,
    output logic              o_rd_we,
    output logic              o_is_branch,
    output logic              o_is_load,
    output logic              o_is_store,
    output logic              o_is_jump,
    output logic              o_is_word,
    output logic              o_illegal
);

    localparam int unsigned ILEN = 32;
    localparam bit          RV64 = (XLEN == 64);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Stored payload; register fields are re-sliced from the held instruction word.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            is_branch;
        logic            is_load;
        logic            is_store;
        logic            is_jump;
        logic            is_word;
        logic            illegal;
    } dec_t;

    logic [6:0]         w_opc;
    logic [4:0]         w_rd;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic signed [31:0] w_imm32;
    logic               w_writes_rd;
    logic               w_illegal;
    dec_t               w_dec;

    dec_t               r_main;
    dec_t               r_skid;
    logic               r_main_valid;
    logic               r_skid_valid;
    logic               r_ready;

    dec_t               w_main_d;
    dec_t               w_skid_d;
    logic               w_main_valid_d;
    logic               w_skid_valid_d;
    logic               w_ready_d;

    logic               w_accept;
    logic               w_drain;

    assign w_opc = i_instr[6:0];
    assign w_rd  = i_instr[11:7];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    // Immediate formats, built at 32 bits then sign-extended to XLEN.
    always_comb begin
        w_imm32 = '0;
        case (w_opc)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32:
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            OPC_STORE:
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            OPC_BRANCH:
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                w_imm32 = {i_instr[31:12], 12'b0};
            OPC_JAL:
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    always_comb begin
        w_writes_rd = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP, OPC_LUI, OPC_JAL, OPC_JALR:
                w_writes_rd = 1'b1;
            OPC_OP_IMM_32, OPC_OP_32:
                w_writes_rd = RV64;
            default:
                w_writes_rd = 1'b0;
        endcase
    end

`ifdef CG_RVDEC_ILLEGAL_EN
    logic w_known_opc;

    always_comb begin
        w_known_opc = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM:
                w_known_opc = 1'b1;
            OPC_OP_IMM_32, OPC_OP_32:
                w_known_opc = RV64;
            default:
                w_known_opc = 1'b0;
        endcase
        w_illegal = 1'b0;
        if (w_opc[1:0] != 2'b11)
            w_illegal = 1'b1;
        if (!w_known_opc)
            w_illegal = 1'b1;
        if ((w_opc == OPC_JALR) && (w_f3 != 3'b000))
            w_illegal = 1'b1;
        if ((w_opc == OPC_BRANCH) && (w_f3[2:1] == 2'b01))
            w_illegal = 1'b1;
        if ((w_opc == OPC_OP) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000))
            w_illegal = 1'b1;
        // Only ADD/SUB and SRL/SRA use the alternate funct7.
        if ((w_opc == OPC_OP) && (w_f7 == 7'b0100000) &&
            (w_f3 != 3'b000) && (w_f3 != 3'b101))
            w_illegal = 1'b1;
    end
`else
    assign w_illegal = 1'b0;
`endif

    always_comb begin
        w_dec           = '0;
        w_dec.pc        = i_pc;
        w_dec.instr     = i_instr;
        w_dec.imm       = XLEN'(w_imm32);
        w_dec.rd_we     = w_writes_rd && (w_rd != 5'd0) && !w_illegal;
        w_dec.is_branch = (w_opc == OPC_BRANCH);
        w_dec.is_load   = (w_opc == OPC_LOAD);
        w_dec.is_store  = (w_opc == OPC_STORE);
        w_dec.is_jump   = (w_opc == OPC_JAL) || (w_opc == OPC_JALR);
        w_dec.is_word   = RV64 && ((w_opc == OPC_OP_IMM_32) || (w_opc == OPC_OP_32));
        w_dec.illegal   = w_illegal;
    end

    assign w_accept = i_valid && r_ready && !i_flush;
    assign w_drain  = r_main_valid && i_ready;

    // Main/skid occupancy; the skid entry always drains first to keep program order.
    always_comb begin
        w_main_d       = r_main;
        w_skid_d       = r_skid;
        w_main_valid_d = r_main_valid;
        w_skid_valid_d = r_skid_valid;
        if (i_flush) begin
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (w_drain && r_skid_valid) begin
            w_main_d       = r_skid;
            w_skid_valid_d = 1'b0;
        end else if (w_accept && (!r_main_valid || w_drain)) begin
            w_main_d       = w_dec;
            w_main_valid_d = 1'b1;
        end else if (w_accept) begin
            w_skid_d       = w_dec;
            w_skid_valid_d = 1'b1;
        end else if (w_drain) begin
            w_main_valid_d = 1'b0;
        end
        w_ready_d = !w_skid_valid_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_main       <= w_main_d;
            r_skid       <= w_skid_d;
            r_main_valid <= w_main_valid_d;
            r_skid_valid <= w_skid_valid_d;
            r_ready      <= w_ready_d;
        end
    end

    assign o_ready     = r_ready;
    assign o_valid     = r_main_valid;
    assign o_pc        = r_main.pc;
    assign o_instr     = r_main.instr;
    assign o_opcode    = r_main.instr[6:0];
    assign o_rd        = r_main.instr[11:7];
    assign o_funct3    = r_main.instr[14:12];
    assign o_rs1       = r_main.instr[19:15];
    assign o_rs2       = r_main.instr[24:20];
    assign o_funct7    = r_main.instr[31:25];
    assign o_imm       = r_main.imm;
    assign o_rd_we     = r_main.rd_we;
    assign o_is_branch = r_main.is_branch;
    assign o_is_load   = r_main.is_load;
    assign o_is_store  = r_main.is_store;
    assign o_is_jump   = r_main.is_jump;
    assign o_is_word   = r_main.is_word;
    assign o_illegal   = r_main.illegal;

endmodule

// File: tb/tb_cg_rvarch_decode_stage.sv
// Scoreboard bench for cg_rvarch_decode_stage: XLEN=64 instance on the handshake, XLEN=32 spot checks.
module tb_cg_rvarch_decode_stage;

`ifdef CG_RVDEC_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        i_flush, i_valid, i_ready;
    logic [31:0] i_instr;
    logic [63:0] i_pc;
    logic        o_ready, o_valid;
    logic [63:0] o_pc, o_imm;
    logic [31:0] o_instr;
    logic [6:0]  o_opcode, o_funct7;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [2:0]  o_funct3;
    logic        o_rd_we, o_is_branch, o_is_load, o_is_store, o_is_jump, o_is_word, o_illegal;

    logic        s_flush, s_valid, s_ready;
    logic [31:0] s_instr, s_pc;
    logic        s_o_ready, s_o_valid;
    logic [31:0] s_o_pc, s_o_imm, s_o_instr;
    logic [6:0]  s_o_opcode, s_o_funct7;
    logic [4:0]  s_o_rd, s_o_rs1, s_o_rs2;
    logic [2:0]  s_o_funct3;
    logic        s_o_rd_we, s_o_is_branch, s_o_is_load, s_o_is_store, s_o_is_jump, s_o_is_word, s_o_illegal;

    cg_rvarch_decode_stage #(.XLEN(64)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
        .o_pc(o_pc), .o_instr(o_instr), .o_opcode(o_opcode), .o_rd(o_rd), .o_rs1(o_rs1),
        .o_rs2(o_rs2), .o_funct3(o_funct3), .o_funct7(o_funct7), .o_imm(o_imm),
        .o_rd_we(o_rd_we), .o_is_branch(o_is_branch), .o_is_load(o_is_load),
        .o_is_store(o_is_store), .o_is_jump(o_is_jump), .o_is_word(o_is_word),
        .o_illegal(o_illegal)
    );

    cg_rvarch_decode_stage #(.XLEN(32)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(s_flush), .i_valid(s_valid), .o_ready(s_o_ready),
        .i_instr(s_instr), .i_pc(s_pc), .o_valid(s_o_valid), .i_ready(s_ready),
        .o_pc(s_o_pc), .o_instr(s_o_instr), .o_opcode(s_o_opcode), .o_rd(s_o_rd), .o_rs1(s_o_rs1),
        .o_rs2(s_o_rs2), .o_funct3(s_o_funct3), .o_funct7(s_o_funct7), .o_imm(s_o_imm),
        .o_rd_we(s_o_rd_we), .o_is_branch(s_o_is_branch), .o_is_load(s_o_is_load),
        .o_is_store(s_o_is_store), .o_is_jump(s_o_is_jump), .o_is_word(s_o_is_word),
        .o_illegal(s_o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {branch, load, store, jump, word, illegal}
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        logic [5:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_pops   = 0;
    int   bubbles  = 0;
    bit   stream_active = 1'b0;

    function automatic exp_t mk(input logic [63:0] pc, input logic [31:0] instr,
                                input logic [63:0] imm, input logic [4:0] rd,
                                input logic rd_we, input logic [5:0] flags);
        exp_t e;
        e.pc = pc; e.instr = instr; e.imm = imm; e.rd = rd; e.rd_we = rd_we; e.flags = flags;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every downstream handshake pops and compares one expected entry.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            n_checks++;
            n_pops++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got instr=%h pc=%h expected nothing", o_instr, o_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_pc !== mon_e.pc || o_instr !== mon_e.instr || o_imm !== mon_e.imm ||
                    o_rd !== mon_e.rd || o_rd_we !== mon_e.rd_we ||
                    {o_is_branch, o_is_load, o_is_store, o_is_jump, o_is_word, o_illegal} !== mon_e.flags) begin
                    n_err++;
                    $display("FAIL scoreboard: got pc=%h instr=%h imm=%h rd=%0d we=%b fl=%b expected pc=%h instr=%h imm=%h rd=%0d we=%b fl=%b",
                             o_pc, o_instr, o_imm, o_rd, o_rd_we,
                             {o_is_branch, o_is_load, o_is_store, o_is_jump, o_is_word, o_illegal},
                             mon_e.pc, mon_e.instr, mon_e.imm, mon_e.rd, mon_e.rd_we, mon_e.flags);
                end
            end
        end
        if (stream_active && !o_valid)
            bubbles++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction; expected entry is queued at the cycle it will be accepted.
    task automatic send(input exp_t e);
        int n = 0;
        i_valid = 1'b1;
        i_instr = e.instr;
        i_pc    = e.pc;
        @(negedge clk);
        while (!o_ready && n < 20) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("send_accept", 64'(o_ready), 64'd1);
        if (o_ready)
            exp_q.push_back(e);
        step();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    exp_t v_addi, v_lui, v_jal, v_addiw, v_zero, v_beq, v_sw, v_lw, v_add0, v_bad_op, v_auipc, v_jalr, v_c;
    exp_t dir_vecs[$];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        v_addi   = mk(64'h1000, 32'hFFF00293, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b1, 6'b000000);
        v_lui    = mk(64'h1004, 32'h123452B7, 64'h0000_0000_1234_5000, 5'd5, 1'b1, 6'b000000);
        v_jal    = mk(64'h1008, 32'h008000EF, 64'd8,                   5'd1, 1'b1, 6'b000100);
        v_addiw  = mk(64'h100C, 32'h0011009B, 64'd1,                   5'd1, 1'b1, 6'b000010);
        v_zero   = mk(64'h1010, 32'h00000000, 64'd0,                   5'd0, 1'b0, {5'b00000, ILL_EN});
        v_beq    = mk(64'h1014, 32'hFE208EE3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd29, 1'b0, 6'b100000);
        v_sw     = mk(64'h1018, 32'h0020A423, 64'd8,                   5'd8, 1'b0, 6'b001000);
        v_lw     = mk(64'h101C, 32'hFF80A183, 64'hFFFF_FFFF_FFFF_FFF8, 5'd3, 1'b1, 6'b010000);
        v_add0   = mk(64'h1020, 32'h00208033, 64'd0,                   5'd0, 1'b0, 6'b000000);
        v_bad_op = mk(64'h1024, 32'h402090B3, 64'd0,                   5'd1, !ILL_EN, {5'b00000, ILL_EN});
        v_auipc  = mk(64'h1028, 32'h80000097, 64'hFFFF_FFFF_8000_0000, 5'd1, 1'b1, 6'b000000);
        v_jalr   = mk(64'h102C, 32'h000100E7, 64'd0,                   5'd1, 1'b1, 6'b000100);
        v_c      = mk(64'h2000, 32'h00100093, 64'd1,                   5'd1, 1'b1, 6'b000000);
        dir_vecs = '{v_lui, v_jal, v_addiw, v_zero, v_beq, v_sw, v_lw, v_add0, v_bad_op, v_auipc, v_jalr};

        rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_instr = '0; i_pc = '0;
        s_flush = 1'b0; s_valid = 1'b0; s_ready = 1'b1; s_instr = '0; s_pc = '0;
        step(); step();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_imm", o_imm, 64'd0);
        chk("rst_instr", 64'(o_instr), 64'd0);
        rst_n = 1'b1;
        step();

        // Single ADDI: visible one cycle after accept.
        send(v_addi);
        i_valid = 1'b0;
        chk("lat_valid", 64'(o_valid), 64'd1);
        chk("lat_rd", 64'(o_rd), 64'd5);
        chk("lat_imm", o_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        foreach (dir_vecs[i]) send(dir_vecs[i]);
        i_valid = 1'b0;
        drain();

        // Back-pressure: LUI held in main, JAL in skid.
        i_ready = 1'b0;
        send(v_lui);
        send(v_jal);
        i_valid = 1'b0;
        chk("stall_ready", 64'(o_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            chk("stall_hold_instr", 64'(o_instr), 64'h123452B7);
            chk("stall_hold_imm", o_imm, 64'h12345000);
            step();
        end
        i_ready = 1'b1;
        step();
        chk("unstall_ready", 64'(o_ready), 64'd1);
        chk("unstall_jump", 64'(o_is_jump), 64'd1);
        drain();

        // Flush with both entries full and a new input presented.
        i_ready = 1'b0;
        send(v_addi);
        send(v_sw);
        i_valid = 1'b1; i_instr = v_c.instr; i_pc = v_c.pc; i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        exp_q.delete();
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        // Flush overrides an accept into an empty stage.
        i_ready = 1'b1;
        i_valid = 1'b1; i_instr = v_c.instr; i_pc = v_c.pc; i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_valid = 1'b0;
        chk("flush_drop_valid", 64'(o_valid), 64'd0);
        send(v_jalr);
        i_valid = 1'b0;
        drain();

        // XLEN=32 instance.
        s_valid = 1'b1; s_instr = 32'h0011009B; s_pc = 32'h40;
        step();
        s_valid = 1'b0;
        chk("x32_valid", 64'(s_o_valid), 64'd1);
        chk("x32_word", 64'(s_o_is_word), 64'd0);
        chk("x32_illegal", 64'(s_o_illegal), 64'(ILL_EN));
        chk("x32_rd_we", 64'(s_o_rd_we), 64'd0);
        s_valid = 1'b1; s_instr = 32'hFFF00293; s_pc = 32'h44;
        step();
        s_valid = 1'b0;
        chk("x32_imm", 64'(s_o_imm), 64'h0000_0000_FFFF_FFFF);
        chk("x32_addi_we", 64'(s_o_rd_we), 64'd1);

        // Streaming: alternating ADDI/LUI with varied rd and immediates.
        begin
            int pops0;
            pops0 = n_pops;
            for (int k = 0; k < 100; k++) begin
                exp_t e;
                logic [4:0]         rd;
                logic [11:0]        im12;
                logic signed [11:0] sim12;
                logic [19:0]        u20;
                logic signed [31:0] su;
                rd = 5'(k % 31 + 1);
                if (k % 2 == 0) begin
                    im12  = 12'(k * 83);
                    sim12 = im12;
                    e = mk(64'h8000 + 64'(4 * k), {im12, 5'd0, 3'b000, rd, 7'b0010011},
                           64'(sim12), rd, 1'b1, 6'b000000);
                end else begin
                    u20 = 20'(k * 40961);
                    su  = {u20, 12'b0};
                    e = mk(64'h8000 + 64'(4 * k), {u20, rd, 7'b0110111},
                           64'(su), rd, 1'b1, 6'b000000);
                end
                send(e);
                if (k == 0)
                    stream_active = 1'b1;
            end
            i_valid = 1'b0;
            step();
            stream_active = 1'b0;
            drain();
            chk("stream_count", 64'(n_pops - pops0), 64'd100);
            chk("stream_bubbles", 64'(bubbles), 64'd0);
        end

        // Asynchronous reset while stalled with both entries full.
        i_ready = 1'b0;
        send(v_lw);
        send(v_beq);
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd1);
        chk("mid_rst_imm", o_imm, 64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        i_ready = 1'b1;
        send(v_auipc);
        i_valid = 1'b0;
        chk("post_rst_valid", 64'(o_valid), 64'd1);
        drain();

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
